fetch_ctrl: RTL and testbench

- Sequences instruction fetch for the front end.
- Owns the fetch PC and issues one ICache request at a time.
- Discards responses made stale by a flush or branch redirect.
- Pushes zero, one or two instructions per response into the instruction FIFO buffer.
- Stops requesting while the buffer reports full.
- Sits between the branch/flush logic and the ICache on one side, and the instruction buffer on the other.

---
 rtl/fetch_ctrl_pkg.sv | 24 ++
 rtl/fetch_pc_next.sv | 43 ++++
 rtl/fetch_ctrl.sv | 147 ++++++++++++++
 tb/tb_fetch_ctrl.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// fetch_ctrl_pkg
// Shared types and constants for the instruction fetch controller.
//   inst_t / addr_t   : 32-bit instruction word and instruction address
//   VALID / INVALID   : push strobe levels toward the instruction buffer
//   ZERO_WORD         : reset / idle value of data and address outputs
//   fetch_state_e     : fetch sequencer states (2-bit encoding)
// ---------------------------------------------------------------------------
package fetch_ctrl_pkg;

    typedef logic [31:0] inst_t;
    typedef logic [31:0] addr_t;

    localparam logic  VALID     = 1'b1;
    localparam logic  INVALID   = 1'b0;
    localparam inst_t ZERO_WORD = 32'h0000_0000;

    typedef enum logic [1:0] {
        FETCH_REQ     = 2'd0,  // free to issue a request at pc
        FETCH_WAIT    = 2'd1,  // one request in flight, response will be used
        FETCH_DISCARD = 2'd2   // one request in flight, response is stale
    } fetch_state_e;

endpackage

// File: rtl/fetch_pc_next.sv
// ---------------------------------------------------------------------------
// fetch_pc_next
// Combinational next-PC selection for the fetch sequencer.
//   req_pc       in  : address of the request whose response is arriving
//   flush        in  : pipeline flush (wins over branch redirect)
//   flush_pc     in  : flush target
//   br_redirect  in  : branch mispredict redirect
//   br_target    in  : branch redirect target
//   redirect     out : either redirect source is active
//   redirect_pc  out : selected redirect target, used unmodified
//   dual         out : response at req_pc carries two usable instructions
//   seq_pc       out : sequential fetch address after the response
// Build option FETCH_DUAL_EN: when defined, an even-word req_pc yields a dual
// response; otherwise every response carries a single instruction.
// ---------------------------------------------------------------------------
module fetch_pc_next
    import fetch_ctrl_pkg::*;
(
    input  logic [31:0] req_pc,
    input  logic        flush,
    input  logic [31:0] flush_pc,
    input  logic        br_redirect,
    input  logic [31:0] br_target,
    output logic        redirect,
    output logic [31:0] redirect_pc,
    output logic        dual,
    output logic [31:0] seq_pc
);

    assign redirect    = flush | br_redirect;
    assign redirect_pc = flush ? flush_pc : br_target;

`ifdef FETCH_DUAL_EN
    // An odd-word PC only gets one instruction, which realigns the next fetch.
    assign dual = ~req_pc[2];
`else
    assign dual = 1'b0;
`endif

    // 32-bit wrapping add; no alignment fix-up of any kind.
    assign seq_pc = req_pc + (dual ? 32'd8 : 32'd4);

endmodule

// File: rtl/fetch_ctrl.sv
// ---------------------------------------------------------------------------
// fetch_ctrl
// Sequences instruction fetch: owns the fetch PC, keeps at most one ICache
// request in flight, drops responses made stale by a flush or branch
// redirect, and pushes one or two instructions per response into the
// instruction buffer. New requests are held off while the buffer is full.
//
// Parameters
//   RESET_PC            fetch address loaded on reset
// Ports
//   clk, rst            clock, synchronous active-high reset
//   flush, flush_pc     pipeline flush and its target (highest priority)
//   br_redirect_i, br_target_i   branch mispredict redirect and target
//   buffer_full_i       instruction buffer full; gates new requests only
//   icache_req_o, icache_addr_o  request valid and fetch address
//   icache_addr_ok_i    request accepted this cycle
//   icache_data_ok_i    response valid this cycle
//   icache_rdata1_i/2_i instructions at req_pc and req_pc+4
//   inst1_o/inst2_o, inst1_addr_o/inst2_addr_o, inst1_valid_o/inst2_valid_o
//                       registered pushes into the instruction buffer
// Build option FETCH_DUAL_EN: enables two-instruction pushes for aligned
// pairs; when undefined inst2_valid_o stays 0 and icache_rdata2_i is unused.
// ---------------------------------------------------------------------------
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic [31:0] flush_pc,
    input  logic        br_redirect_i,
    input  logic [31:0] br_target_i,
    input  logic        buffer_full_i,
    output logic        icache_req_o,
    output logic [31:0] icache_addr_o,
    input  logic        icache_addr_ok_i,
    input  logic        icache_data_ok_i,
    input  logic [31:0] icache_rdata1_i,
    input  logic [31:0] icache_rdata2_i,
    output logic [31:0] inst1_o,
    output logic [31:0] inst2_o,
    output logic [31:0] inst1_addr_o,
    output logic [31:0] inst2_addr_o,
    output logic        inst1_valid_o,
    output logic        inst2_valid_o
);

    fetch_state_e state;
    addr_t        pc;
    addr_t        req_pc;

    logic         redirect;
    addr_t        redirect_pc;
    logic         dual;
    addr_t        seq_pc;

    fetch_pc_next u_pc_next (
        .req_pc      (req_pc),
        .flush       (flush),
        .flush_pc    (flush_pc),
        .br_redirect (br_redirect_i),
        .br_target   (br_target_i),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .dual        (dual),
        .seq_pc      (seq_pc)
    );

`ifndef FETCH_DUAL_EN
    logic unused_rdata2;
    assign unused_rdata2 = ^icache_rdata2_i;
`endif

    // A redirect cycle never issues a request: the address would already be stale.
    assign icache_req_o  = ~rst & (state == FETCH_REQ) & ~buffer_full_i & ~redirect;
    assign icache_addr_o = pc;

    // NOTE: all state and output registers use non-blocking assignments so every
    // branch below reads the pre-edge values of pc, req_pc and state.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the buffer-facing data/address registers are reset too, not just
            // the strobes, so the outputs are deterministic straight out of reset.
            state         <= FETCH_REQ;
            pc            <= RESET_PC;
            req_pc        <= RESET_PC;
            inst1_o       <= ZERO_WORD;
            inst2_o       <= ZERO_WORD;
            inst1_addr_o  <= ZERO_WORD;
            inst2_addr_o  <= ZERO_WORD;
            inst1_valid_o <= INVALID;
            inst2_valid_o <= INVALID;
        end else begin
            // Push strobes are single-cycle pulses.
            inst1_valid_o <= INVALID;
            inst2_valid_o <= INVALID;

            case (state)
                FETCH_REQ: begin
                    // data_ok here belongs to no request of ours and is ignored.
                    if (redirect) begin
                        pc <= redirect_pc;
                    end else if (icache_req_o && icache_addr_ok_i) begin
                        req_pc <= pc;
                        state  <= FETCH_WAIT;
                    end
                end

                FETCH_WAIT: begin
                    if (redirect) begin
                        // A response arriving in the redirect cycle is already stale.
                        pc    <= redirect_pc;
                        state <= icache_data_ok_i ? FETCH_REQ : FETCH_DISCARD;
                    end else if (icache_data_ok_i) begin
                        // Pushed regardless of buffer_full_i; the buffer keeps slack.
                        inst1_o       <= icache_rdata1_i;
                        inst1_addr_o  <= req_pc;
                        inst1_valid_o <= VALID;
                        inst2_addr_o  <= req_pc + 32'd4;
                        inst2_valid_o <= dual;
`ifdef FETCH_DUAL_EN
                        inst2_o       <= icache_rdata2_i;
`else
                        inst2_o       <= ZERO_WORD;
`endif
                        pc            <= seq_pc;
                        state         <= FETCH_REQ;
                    end
                end

                FETCH_DISCARD: begin
                    if (redirect) begin
                        pc <= redirect_pc;
                    end
                    if (icache_data_ok_i) begin
                        state <= FETCH_REQ;
                    end
                end

                default: state <= FETCH_REQ;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fetch_ctrl
// Self-checking bench for fetch_ctrl. The driver plays the ICache and keeps a
// transaction-level reference: the expected next fetch address, whether a
// request is in flight, and whether a redirect has made it stale. Each usable
// response pushes its expected buffer write into a scoreboard queue; a
// separate monitor pops and compares whenever the DUT strobes inst1_valid_o.
// Honours FETCH_DUAL_EN the same way the design does.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_fetch_ctrl;

    localparam logic [31:0] RESET_PC = 32'hBFC0_0000;
`ifdef FETCH_DUAL_EN
    localparam bit DUAL_EN = 1'b1;
`else
    localparam bit DUAL_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic [31:0] flush_pc = '0;
    logic        br_redirect_i = 1'b0;
    logic [31:0] br_target_i = '0;
    logic        buffer_full_i = 1'b0;
    logic        icache_req_o;
    logic [31:0] icache_addr_o;
    logic        icache_addr_ok_i = 1'b0;
    logic        icache_data_ok_i = 1'b0;
    logic [31:0] icache_rdata1_i = '0;
    logic [31:0] icache_rdata2_i = '0;
    logic [31:0] inst1_o, inst2_o, inst1_addr_o, inst2_addr_o;
    logic        inst1_valid_o, inst2_valid_o;

    fetch_ctrl #(.RESET_PC(RESET_PC)) dut (
        .clk              (clk),
        .rst              (rst),
        .flush            (flush),
        .flush_pc         (flush_pc),
        .br_redirect_i    (br_redirect_i),
        .br_target_i      (br_target_i),
        .buffer_full_i    (buffer_full_i),
        .icache_req_o     (icache_req_o),
        .icache_addr_o    (icache_addr_o),
        .icache_addr_ok_i (icache_addr_ok_i),
        .icache_data_ok_i (icache_data_ok_i),
        .icache_rdata1_i  (icache_rdata1_i),
        .icache_rdata2_i  (icache_rdata2_i),
        .inst1_o          (inst1_o),
        .inst2_o          (inst2_o),
        .inst1_addr_o     (inst1_addr_o),
        .inst2_addr_o     (inst2_addr_o),
        .inst1_valid_o    (inst1_valid_o),
        .inst2_valid_o    (inst2_valid_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] i1, a1, i2, a2;
        logic        v2;
    } push_t;

    push_t       sb[$];
    int          checks = 0;
    int          errors = 0;

    // Reference state, transaction level.
    logic [31:0] exp_pc = RESET_PC;
    logic [31:0] req_addr = '0;
    bit          outstanding = 1'b0;
    bit          stale = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ICache contents: an address-derived word, so every slot is distinguishable.
    function automatic logic [31:0] mem(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hA5A5_5A5A;
    endfunction

    function automatic bit dual_at(input logic [31:0] a);
        return DUAL_EN && (a[2] == 1'b0);
    endfunction

    function automatic logic [31:0] rand_target();
        logic [31:0] t;
        case ($urandom_range(0, 9))
            0:       t = 32'hFFFF_FFF8;
            1:       t = 32'hFFFF_FFFC;
            2:       t = $urandom;                    // unaligned, used as-is
            default: t = $urandom & 32'hFFFF_FFFC;
        endcase
        return t;
    endfunction

    // One clock cycle of stimulus plus reference update.
    //   acc   : accept a request if one is expected this cycle
    //   dat   : return data for the in-flight request
    //   stray : raise data_ok although nothing is in flight
    task automatic step(input bit f, input logic [31:0] fpc, input bit b, input logic [31:0] bt,
                        input bit full, input bit acc, input bit dat, input bit stray);
        bit          redir;
        bit          exp_req;
        logic [31:0] tgt;
        push_t       e;
        @(posedge clk);
        #1;
        flush            = f;
        flush_pc         = fpc;
        br_redirect_i    = b;
        br_target_i      = bt;
        buffer_full_i    = full;
        icache_addr_ok_i = 1'b0;
        icache_data_ok_i = 1'b0;
        icache_rdata1_i  = $urandom;
        icache_rdata2_i  = $urandom;
        redir   = f | b;
        tgt     = f ? fpc : bt;
        exp_req = !outstanding && !full && !redir;
        #1;
        check("icache_req", {31'd0, icache_req_o}, {31'd0, exp_req});
        if (exp_req) check("icache_addr", icache_addr_o, exp_pc);

        if (outstanding && dat) begin
            icache_data_ok_i = 1'b1;
            icache_rdata1_i  = mem(req_addr);
            icache_rdata2_i  = mem(req_addr + 32'd4);
            if (!stale && !redir) begin
                e.i1 = mem(req_addr);
                e.a1 = req_addr;
                e.v2 = dual_at(req_addr);
                e.i2 = mem(req_addr + 32'd4);
                e.a2 = req_addr + 32'd4;
                sb.push_back(e);
                exp_pc = req_addr + (e.v2 ? 32'd8 : 32'd4);
            end
            outstanding = 1'b0;
            stale       = 1'b0;
        end else if (!outstanding && stray) begin
            icache_data_ok_i = 1'b1;
        end else if (exp_req && acc) begin
            icache_addr_ok_i = 1'b1;
            req_addr         = exp_pc;
            outstanding      = 1'b1;
        end

        if (redir) begin
            exp_pc = tgt;
            if (outstanding) stale = 1'b1;
        end
    endtask

    task automatic idle();                      step(0, 32'd0, 0, 32'd0, 0, 0, 0, 0); endtask
    task automatic go();                        step(0, 32'd0, 0, 32'd0, 0, 1, 0, 0); endtask
    task automatic resp();                      step(0, 32'd0, 0, 32'd0, 0, 0, 1, 0); endtask
    task automatic brr(input logic [31:0] t);   step(0, 32'd0, 1, t, 0, 0, 0, 0);     endtask
    task automatic fl(input logic [31:0] t);    step(1, t, 0, 32'd0, 0, 0, 0, 0);     endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst              = 1'b1;
        flush            = 1'b0;
        br_redirect_i    = 1'b0;
        buffer_full_i    = 1'b0;
        icache_addr_ok_i = 1'b0;
        icache_data_ok_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_req",         {31'd0, icache_req_o},  32'd0);
        check("rst_inst1_valid", {31'd0, inst1_valid_o}, 32'd0);
        check("rst_inst2_valid", {31'd0, inst2_valid_o}, 32'd0);
        check("rst_inst1",       inst1_o,                32'd0);
        check("rst_inst2",       inst2_o,                32'd0);
        check("rst_inst1_addr",  inst1_addr_o,           32'd0);
        check("rst_inst2_addr",  inst2_addr_o,           32'd0);
        check("rst_pc",          icache_addr_o,          RESET_PC);
        rst         = 1'b0;
        outstanding = 1'b0;
        stale       = 1'b0;
        exp_pc      = RESET_PC;
        sb.delete();
    endtask

    // Monitor: every push strobe must match the oldest expected push.
    always @(negedge clk) begin
        push_t e;
        if (!rst) begin
            if (inst1_valid_o) begin
                if (sb.size() == 0) begin
                    check("unexpected_push", {31'd0, inst1_valid_o}, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("inst1",       inst1_o,                 e.i1);
                    check("inst1_addr",  inst1_addr_o,            e.a1);
                    check("inst2_valid", {31'd0, inst2_valid_o}, {31'd0, e.v2});
                    if (e.v2) begin
                        check("inst2",      inst2_o,      e.i2);
                        check("inst2_addr", inst2_addr_o, e.a2);
                    end
                end
            end else if (inst2_valid_o) begin
                check("inst2_alone", {31'd0, inst2_valid_o}, 32'd0);
            end
        end
    end

    initial begin
        do_reset();

        // Reset and first fetches, minimum spacing.
        go(); resp(); go(); resp(); go(); resp();

        // Odd-word start via branch redirect in REQ.
        brr(32'h8000_0004);
        go(); resp(); go(); resp(); idle();

        // Redirect while waiting; the late response is stale.
        go(); brr(32'h8000_1000); idle(); resp();
        go(); resp();

        // Flush and branch together: flush target wins.
        step(1, 32'h8000_2000, 1, 32'h8000_3000, 0, 1, 0, 0);
        go(); resp();

        // Full buffer in REQ holds requests off; resumes when it drops.
        repeat (5) step(0, 32'd0, 0, 32'd0, 1, 1, 0, 0);
        go();
        // Full buffer while waiting: the response is still pushed.
        step(0, 32'd0, 0, 32'd0, 1, 0, 1, 0);
        step(0, 32'd0, 0, 32'd0, 1, 0, 0, 0);

        // Redirect in the same cycle as data_ok drops the response.
        go(); step(0, 32'd0, 1, 32'h8000_4008, 0, 0, 1, 0);
        go(); resp();

        // Redirects while discarding: the last one wins.
        go(); brr(32'h8000_5000); brr(32'h8000_6004); fl(32'h8000_7000); resp();
        go(); resp();

        // Wrap-around at the top of the address space.
        brr(32'hFFFF_FFF8);
        go(); resp(); go(); resp();
        brr(32'hFFFF_FFFC);
        go(); resp(); go(); resp();

        // Reset mid-request; a late data_ok in REQ is ignored.
        go(); do_reset();
        step(0, 32'd0, 0, 32'd0, 0, 0, 0, 1);
        go(); resp(); idle();

        // Randomized traffic.
        for (int i = 0; i < 4000; i++) begin
            step($urandom_range(0, 15) == 0, rand_target(),
                 $urandom_range(0, 7) == 0,  rand_target(),
                 $urandom_range(0, 3) == 0,
                 $urandom_range(0, 3) != 0,
                 $urandom_range(0, 2) != 0,
                 $urandom_range(0, 15) == 0);
            if ($urandom_range(0, 999) == 0) do_reset();
        end

        // Drain: finish any in-flight request and let the last push appear.
        resp(); idle(); idle(); idle();
        check("sb_empty", sb.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
